// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  // Default operand/result width.
  localparam int unsigned DIV_W = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  // Width needed to count 0..n-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// Ripple-carry adder/subtractor: B is XOR-inverted by sub_i, which also feeds the carry-in.
module addsub_unit #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] bx_c;
  logic         carry_c;

  assign bx_c = b_i ^ {W{sub_i}};

  // Bit-serial carry chain, LSB first.
  always_comb begin
    carry_c = sub_i;
    sum_o   = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum_o[i] = a_i[i] ^ bx_c[i] ^ carry_c;
      carry_c  = (a_i[i] & bx_c[i]) | (carry_c & (a_i[i] ^ bx_c[i]));
    end
  end

  assign cout_o = carry_c;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock through a shared
// N+1-bit subtractor, start/busy/done handshake.
// Optional macro SIGNED_DIV_EN: two's-complement operands, truncating division.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = clog2(N);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic [N:0]    r_q, r_d;
  logic [N:0]    d_q, d_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;

  logic [N:0]    s_c;
  logic [N:0]    diff_c;
  logic          no_borrow_c;
  logic [N-1:0]  q_next_c;
  logic [N:0]    r_next_c;
  logic [N-1:0]  a_load_c;
  logic [N-1:0]  b_load_c;
  logic [N-1:0]  q_fin_c;
  logic [N-1:0]  r_fin_c;

  // R stays below the divisor, so its top bit is only headroom for the shift.
  logic          unused_ok;
  assign unused_ok = r_q[N];

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign s_c = {r_q[N-1:0], q_q[N-1]};

  addsub_unit #(
    .W(N + 1)
  ) u_addsub (
    .a_i   (s_c),
    .b_i   (d_q),
    .sub_i (1'b1),
    .sum_o (diff_c),
    .cout_o(no_borrow_c)
  );

  assign q_next_c = {q_q[N-2:0], no_borrow_c};
  assign r_next_c = no_borrow_c ? diff_c : s_c;

`ifdef SIGNED_DIV_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;

  // Divide magnitudes; fix up signs when the results are published.
  assign a_load_c = dividend[N-1] ? (~dividend + N'(1)) : dividend;
  assign b_load_c = divisor[N-1]  ? (~divisor + N'(1))  : divisor;
  assign q_fin_c  = neg_q_q ? (~q_next_c + N'(1)) : q_next_c;
  assign r_fin_c  = neg_r_q ? (~r_next_c[N-1:0] + N'(1)) : r_next_c[N-1:0];

  // Sign flags captured with the operands.
  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (state_q == IDLE && start) begin
      neg_q_d = dividend[N-1] ^ divisor[N-1];
      neg_r_d = dividend[N-1];
    end
  end

  // Sign flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  assign a_load_c = dividend;
  assign b_load_c = divisor;
  assign q_fin_c  = q_next_c;
  assign r_fin_c  = r_next_c[N-1:0];
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_d    = a_load_c;
          d_d    = {1'b0, b_load_c};
          r_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          dbz_d  = 1'b0;
          if (divisor == '0) begin
            // Zero divisor bypasses the iteration entirely.
            state_d = DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = dividend;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        q_d   = q_next_c;
        r_d   = r_next_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          quo_d   = q_fin_c;
          rem_d   = r_fin_c;
        end
      end

      DONE: begin
        // Start is not sampled here; a held start is taken in the following IDLE cycle.
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=32): directed divisions, divide-by-zero,
// held-start back-to-back ops, and reset abort.
module tb_seq_divider;

  localparam int unsigned N = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int unsigned  cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient",    64'(quotient),    64'(e.q));
        check("remainder",   64'(remainder),   64'(e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        check("done_cycle",  64'(cyc),         64'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: got busy stuck high, expected idle within 300 cycles");
  endtask

  // Issue one single-cycle start pulse and log the expected result.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic edbz);
    exp_t e;
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.cyc = cyc + 32'd1 + (edbz ? 32'd0 : 32'(N));
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  initial begin
    exp_t e1;
    exp_t e2;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   64'(busy),        64'(0));
    check("rst_done",   64'(done),        64'(0));
    check("rst_quot",   64'(quotient),    64'(0));
    check("rst_rem",    64'(remainder),   64'(0));
    check("rst_dbz",    64'(div_by_zero), 64'(0));
    rst = 1'b0;

    do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_op(32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    do_op(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    do_op(32'd100, 32'd10, 32'd10, 32'd0, 1'b0);

    // Held start: second op is taken the cycle after DONE, using the new operands.
    wait_idle();
    dividend = 32'd20;
    divisor  = 32'd3;
    start    = 1'b1;
    e1.q = 32'd6; e1.r = 32'd2; e1.dbz = 1'b0; e1.cyc = cyc + 32'd1 + 32'(N);
    exp_q.push_back(e1);
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd8;
    e2.q = 32'd6; e2.r = 32'd2; e2.dbz = 1'b0; e2.cyc = e1.cyc + 32'd2 + 32'(N);
    exp_q.push_back(e2);
    for (int i = 0; i < 200 && cyc < e1.cyc + 32'd2; i++) @(negedge clk);
    start = 1'b0;

    // Abort mid-operation: no done, everything back to reset values.
    wait_idle();
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy),        64'(0));
    check("abort_done", 64'(done),        64'(0));
    check("abort_quot", 64'(quotient),    64'(0));
    check("abort_rem",  64'(remainder),   64'(0));
    check("abort_dbz",  64'(div_by_zero), 64'(0));
    rst = 1'b0;
    repeat (40) @(negedge clk);

    do_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

`ifdef SIGNED_DIV_EN
    do_op(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_op(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, expected finish");
    $fatal(1);
  end

endmodule
